// File: rtl/pe_traffic_gen.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : pe_traffic_gen
// Brief    : NoC endpoint with credit-controlled multi-flit packet injection,
//            traffic sink with one-cycle credit return, and statistics.
// Revision : 1.0
// =============================================================================
module pe_traffic_gen #(
  parameter int NUM_VCS         = 2,
  parameter int NUM_RECV_PORTS  = 16,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int BUFFER_DEPTH    = 8,
  parameter int PKT_LEN         = 4,
  parameter int INJ_PERIOD      = 10,
  parameter int SRC_ID          = 0,
  localparam int VC_W   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int DEST_W = $clog2(NUM_RECV_PORTS),
  localparam int FW     = 2 + FLIT_DATA_WIDTH + DEST_W + VC_W,
  localparam int CRW    = 1 + VC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [FW-1:0]     flit_in,
  output logic [FW-1:0]     flit_out,
  output logic              sendFlit,
  output logic              en_receiveFlit,
  input  logic [CRW-1:0]    credit_in,
  output logic [CRW-1:0]    credit_out,
  output logic              sendCredit,
  output logic              en_receiveCredit,
  input  logic [DEST_W-1:0] recvPortID,
  input  logic [1:0]        cfg_dest_mode,
  input  logic [DEST_W-1:0] cfg_dest,
  output logic [31:0]       tx_pkt_cnt,
  output logic [31:0]       rx_flit_cnt,
  output logic [31:0]       rx_pkt_cnt,
  output logic [15:0]       drop_cnt,
  output logic              err_credit_ovf,
  output logic              err_misroute
);

  localparam int CW    = $clog2(BUFFER_DEPTH + 1);
  localparam int SEQ_W = FLIT_DATA_WIDTH - 16;
  localparam int TW    = (INJ_PERIOD > 1) ? $clog2(INJ_PERIOD) : 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(BUFFER_DEPTH);
  localparam logic [7:0]    SRC8       = 8'(SRC_ID);
  localparam logic [0:0]    S_IDLE     = 1'b0;
  localparam logic [0:0]    S_SEND     = 1'b1;

  logic [0:0]        r_state;
  logic [TW-1:0]     r_timer;
  logic              r_pending;
  logic [SEQ_W-1:0]  r_seq;
  logic [15:0]       r_lfsr;
  logic [DEST_W-1:0] r_rr_dest;
  logic [VC_W-1:0]   r_vc_rr;
  logic [VC_W-1:0]   r_cur_vc;
  logic [DEST_W-1:0] r_cur_dest;
  logic [7:0]        r_flit_idx;
  logic [FW-1:0]     r_flit_out;
  logic              r_send_flit;
  logic              r_send_credit;
  logic [VC_W-1:0]   r_credit_vc;
  logic [31:0]       r_tx_pkt_cnt;
  logic [31:0]       r_rx_flit_cnt;
  logic [31:0]       r_rx_pkt_cnt;
  logic [15:0]       r_drop_cnt;
  logic              r_err_ovf;
  logic              r_err_misroute;

  logic [NUM_VCS-1:0] w_has_credit;
  logic [NUM_VCS-1:0] w_ovf;
  logic               w_wrap, w_take, w_fire, w_last;
  logic               w_cr_valid;
  logic [VC_W-1:0]    w_cr_vc;
  logic               w_rx_valid, w_rx_tail;
  logic [DEST_W-1:0]  w_rx_dest;
  logic [VC_W-1:0]    w_rx_vc;
  logic [DEST_W-1:0]  w_rr_inc, w_rr_pick, w_lfsr_pick, w_dest;
  logic               w_lfsr_fb;
  logic [FW-1:0]      w_flit;
  logic               w_unused;

  function automatic logic [DEST_W-1:0] f_next_port(input logic [DEST_W-1:0] p);
    return (p == DEST_W'(NUM_RECV_PORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_wrap = en && (r_timer == TW'(INJ_PERIOD - 1));
  assign w_take = en && (r_state == S_IDLE) && r_pending;
  assign w_fire = en && (r_state == S_SEND) && w_has_credit[r_cur_vc];
  assign w_last = (r_flit_idx == 8'(PKT_LEN - 1));

  assign w_cr_valid = en && credit_in[CRW-1];
  assign w_cr_vc    = credit_in[VC_W-1:0];

  assign w_rx_valid = en && flit_in[FW-1];
  assign w_rx_tail  = flit_in[FW-2];
  assign w_rx_dest  = flit_in[FW-3 -: DEST_W];
  assign w_rx_vc    = flit_in[FLIT_DATA_WIDTH +: VC_W];
  assign w_unused   = ^flit_in[FLIT_DATA_WIDTH-1:0];

  // Destination candidates never target this endpoint: a self hit moves on by one.
  assign w_rr_inc    = f_next_port(r_rr_dest);
  assign w_rr_pick   = (w_rr_inc == recvPortID) ? f_next_port(w_rr_inc) : w_rr_inc;
  assign w_lfsr_pick = (r_lfsr[DEST_W-1:0] == recvPortID) ? f_next_port(r_lfsr[DEST_W-1:0])
                                                          : r_lfsr[DEST_W-1:0];
  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_comb begin
    w_dest = cfg_dest;
    case (cfg_dest_mode)
      2'd1:    w_dest = w_rr_pick;
      2'd2:    w_dest = w_lfsr_pick;
      default: w_dest = cfg_dest;
    endcase
  end

  assign w_flit = {1'b1, w_last, r_cur_dest, r_cur_vc, r_seq, r_flit_idx, SRC8};

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_credit
    logic [CW-1:0] r_credit;
    logic          w_dec, w_inc;
    assign w_dec           = w_fire && (r_cur_vc == VC_W'(v));
    assign w_inc           = w_cr_valid && (w_cr_vc == VC_W'(v));
    assign w_has_credit[v] = (r_credit != '0);
    assign w_ovf[v]        = w_inc && !w_dec && (r_credit == CREDIT_MAX);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_credit <= CREDIT_MAX;
      end else if (w_inc && !w_dec && !w_ovf[v]) begin
        r_credit <= r_credit + 1'b1;
      end else if (w_dec && !w_inc) begin
        r_credit <= r_credit - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_pending      <= 1'b0;
      r_seq          <= '0;
      r_lfsr         <= 16'h0001;
      r_rr_dest      <= '0;
      r_vc_rr        <= '0;
      r_cur_vc       <= '0;
      r_cur_dest     <= '0;
      r_flit_idx     <= '0;
      r_flit_out     <= '0;
      r_send_flit    <= 1'b0;
      r_send_credit  <= 1'b0;
      r_credit_vc    <= '0;
      r_tx_pkt_cnt   <= '0;
      r_rx_flit_cnt  <= '0;
      r_rx_pkt_cnt   <= '0;
      r_drop_cnt     <= '0;
      r_err_ovf      <= 1'b0;
      r_err_misroute <= 1'b0;
    end else begin
      if (w_wrap)  r_timer <= '0;
      else if (en) r_timer <= r_timer + 1'b1;

      // A wrap in the same cycle the FSM consumes the request re-arms it.
      if (w_wrap)      r_pending <= 1'b1;
      else if (w_take) r_pending <= 1'b0;
      if (w_wrap && r_pending && !w_take && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_cur_dest <= w_dest;
            r_cur_vc   <= r_vc_rr;
            r_flit_idx <= '0;
            r_state    <= S_SEND;
            if (cfg_dest_mode == 2'd1) r_rr_dest <= w_rr_pick;
            if (cfg_dest_mode == 2'd2) r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
          end
        end
        default: begin
          if (w_fire) begin
            if (w_last) begin
              r_tx_pkt_cnt <= r_tx_pkt_cnt + 32'd1;
              r_seq        <= r_seq + 1'b1;
              r_vc_rr      <= (r_vc_rr == VC_W'(NUM_VCS - 1)) ? '0 : r_vc_rr + 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_flit_idx <= r_flit_idx + 8'd1;
            end
          end
        end
      endcase

      r_send_flit <= w_fire;
      r_flit_out  <= w_fire ? w_flit : '0;

      r_send_credit <= w_rx_valid;
      r_credit_vc   <= w_rx_valid ? w_rx_vc : '0;
      if (w_rx_valid) begin
        r_rx_flit_cnt <= r_rx_flit_cnt + 32'd1;
        if (w_rx_tail)               r_rx_pkt_cnt   <= r_rx_pkt_cnt + 32'd1;
        if (w_rx_dest != recvPortID) r_err_misroute <= 1'b1;
      end

      if (|w_ovf) r_err_ovf <= 1'b1;
    end
  end

  assign flit_out         = r_flit_out;
  assign sendFlit         = r_send_flit;
  assign credit_out       = {r_send_credit, r_credit_vc};
  assign sendCredit       = r_send_credit;
  assign en_receiveFlit   = en && !rst;
  assign en_receiveCredit = en && !rst;
  assign tx_pkt_cnt       = r_tx_pkt_cnt;
  assign rx_flit_cnt      = r_rx_flit_cnt;
  assign rx_pkt_cnt       = r_rx_pkt_cnt;
  assign drop_cnt         = r_drop_cnt;
  assign err_credit_ovf   = r_err_ovf;
  assign err_misroute     = r_err_misroute;

endmodule
`default_nettype wire

// File: tb/tb_pe_traffic_gen.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_pe_traffic_gen
// Brief    : Scoreboard bench for pe_traffic_gen with directed stimulus.
// Revision : 1.0
// =============================================================================
module tb_pe_traffic_gen;

  localparam int FDW     = 32;
  localparam int PKT_LEN = 4;
  localparam int SRC_ID  = 0;
  localparam int DEST_W  = 4;
  localparam int FW      = 2 + FDW + DEST_W + 1;
  localparam int CRW     = 2;

  logic              clk = 1'b0;
  logic              rst, en;
  logic [FW-1:0]     flit_in, flit_out;
  logic              sendFlit, en_receiveFlit, sendCredit, en_receiveCredit;
  logic [CRW-1:0]    credit_in, credit_out;
  logic [DEST_W-1:0] recvPortID, cfg_dest;
  logic [1:0]        cfg_dest_mode;
  logic [31:0]       tx_pkt_cnt, rx_flit_cnt, rx_pkt_cnt;
  logic [15:0]       drop_cnt;
  logic              err_credit_ovf, err_misroute;

  always #5 clk = ~clk;

  pe_traffic_gen #(
    .NUM_VCS(2), .NUM_RECV_PORTS(16), .FLIT_DATA_WIDTH(FDW), .BUFFER_DEPTH(8),
    .PKT_LEN(PKT_LEN), .INJ_PERIOD(10), .SRC_ID(SRC_ID)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .flit_in(flit_in), .flit_out(flit_out), .sendFlit(sendFlit),
    .en_receiveFlit(en_receiveFlit),
    .credit_in(credit_in), .credit_out(credit_out), .sendCredit(sendCredit),
    .en_receiveCredit(en_receiveCredit),
    .recvPortID(recvPortID), .cfg_dest_mode(cfg_dest_mode), .cfg_dest(cfg_dest),
    .tx_pkt_cnt(tx_pkt_cnt), .rx_flit_cnt(rx_flit_cnt), .rx_pkt_cnt(rx_pkt_cnt),
    .drop_cnt(drop_cnt), .err_credit_ovf(err_credit_ovf), .err_misroute(err_misroute)
  );

  // Scoreboard queues: expected flits, expected credits, and posted scalar checks.
  logic [FW-1:0]  sb_flit[$];
  logic [CRW-1:0] sb_cred[$];
  string          chk_name[$];
  logic [63:0]    chk_got[$];
  logic [63:0]    chk_exp[$];
  int             checks = 0;
  int             errors = 0;

  // Credit-return driver controls (main writes limits, driver owns the done counts).
  int   ret_limit = 0, ret_done = 0;
  int   man_req = 0, man_done = 0;
  logic man_vc = 1'b0;

  function automatic logic [FW-1:0] mk_flit(input logic [15:0] s, input logic [7:0] i,
                                            input logic v, input logic [3:0] d);
    return {1'b1, (i == 8'(PKT_LEN - 1)), d, v, s, i, 8'(SRC_ID)};
  endfunction

  task automatic push_pkt(input logic [15:0] s, input logic v, input logic [3:0] d);
    for (int i = 0; i < PKT_LEN; i++) sb_flit.push_back(mk_flit(s, 8'(i), v, d));
  endtask

  task automatic post(input string n, input logic [63:0] g, input logic [63:0] e);
    chk_name.push_back(n);
    chk_got.push_back(g);
    chk_exp.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx(input string n, input int target, input int budget);
    int k = 0;
    while (tx_pkt_cnt != 32'(target) && k < budget) begin
      @(negedge clk);
      k++;
    end
    post(n, 64'(tx_pkt_cnt), 64'(target));
  endtask

  task automatic rx_flit(input logic v, input logic [3:0] d, input logic t);
    flit_in = {1'b1, t, d, v, 32'hC0DE_0000};
    sb_cred.push_back({1'b1, v});
    @(negedge clk);
  endtask

  // Monitor: compares DUT outputs against the scoreboard whenever they are presented.
  initial begin
    logic [FW-1:0]  ef;
    logic [CRW-1:0] ec;
    logic [63:0]    g, e;
    string          n;
    forever begin
      @(negedge clk);
      if (sendFlit) begin
        checks++;
        if (sb_flit.size() == 0) begin
          errors++;
          $display("FAIL flit_unexpected got=%h required=none", flit_out);
        end else begin
          ef = sb_flit.pop_front();
          if (flit_out !== ef) begin
            errors++;
            $display("FAIL flit got=%h required=%h", flit_out, ef);
          end
        end
      end
      if (sendCredit) begin
        checks++;
        if (sb_cred.size() == 0) begin
          errors++;
          $display("FAIL credit_unexpected got=%b required=none", credit_out);
        end else begin
          ec = sb_cred.pop_front();
          if (credit_out !== ec) begin
            errors++;
            $display("FAIL credit got=%b required=%b", credit_out, ec);
          end
        end
      end
      while (chk_name.size() > 0) begin
        n = chk_name.pop_front();
        g = chk_got.pop_front();
        e = chk_exp.pop_front();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL %s got=%0h required=%0h", n, g, e);
        end
      end
    end
  end

  // Router-side credit source: echoes credits for observed flits, plus manual credits.
  initial begin
    credit_in = '0;
    forever begin
      @(negedge clk);
      if (sendFlit && ret_done < ret_limit) begin
        credit_in = {1'b1, flit_out[FDW]};
        ret_done++;
      end else if (man_done < man_req) begin
        credit_in = {1'b1, man_vc};
        man_done++;
      end else begin
        credit_in = '0;
      end
    end
  end

  initial begin
    logic [15:0] d0;
    rst = 1'b1; en = 1'b0; flit_in = '0;
    recvPortID = 4'd5; cfg_dest_mode = 2'd0; cfg_dest = 4'd3;
    tick(3);
    post("rst_strobes", 64'({sendFlit, sendCredit, en_receiveFlit, en_receiveCredit}), 64'd0);
    post("rst_flit_out", 64'(flit_out), 64'd0);
    post("rst_credit_out", 64'(credit_out), 64'd0);
    post("rst_tx_cnt", 64'(tx_pkt_cnt), 64'd0);
    post("rst_rx_cnts", {rx_flit_cnt, rx_pkt_cnt}, 64'd0);
    post("rst_drop_err", 64'({drop_cnt, err_credit_ovf, err_misroute}), 64'd0);

    // Fixed destination, no credit return: 8 flits per VC, then stall.
    rst = 1'b0; en = 1'b1;
    push_pkt(16'd0, 1'b0, 4'd3);
    push_pkt(16'd1, 1'b1, 4'd3);
    push_pkt(16'd2, 1'b0, 4'd3);
    push_pkt(16'd3, 1'b1, 4'd3);
    tick(1);
    post("en_receive", 64'({en_receiveFlit, en_receiveCredit}), 64'b11);
    wait_tx("tx_first_pkt", 1, 40);
    wait_tx("tx_credit_limit", 4, 100);
    tick(25);
    post("sb_after_stall", 64'(sb_flit.size()), 64'd0);
    d0 = drop_cnt;
    tick(30);
    post("drop_3_wraps", 64'(drop_cnt - d0), 64'd3);

    // One credit on vc0 releases exactly one flit.
    man_vc = 1'b0;
    sb_flit.push_back(mk_flit(16'd4, 8'd0, 1'b0, 4'd3));
    man_req = man_req + 1;
    tick(10);
    post("sb_one_credit", 64'(sb_flit.size()), 64'd0);
    post("tx_one_credit", 64'(tx_pkt_cnt), 64'd4);

    // Disable mid-packet: everything freezes, then the packet resumes at flit 1.
    en = 1'b0;
    d0 = drop_cnt;
    tick(50);
    post("drop_frozen", 64'(drop_cnt - d0), 64'd0);
    en = 1'b1;
    for (int i = 1; i < PKT_LEN; i++) sb_flit.push_back(mk_flit(16'd4, 8'(i), 1'b0, 4'd3));
    man_req = man_req + 3;
    wait_tx("tx_resume", 5, 30);
    tick(3);
    post("sb_resume", 64'(sb_flit.size()), 64'd0);

    // Reset mid-packet with a flit arriving: nothing is accepted, all outputs clear.
    rst = 1'b1;
    flit_in = {1'b1, 1'b1, 4'd5, 1'b1, 32'h0};
    tick(1);
    flit_in = '0;
    post("rstmid_strobes", 64'({sendFlit, sendCredit, en_receiveFlit}), 64'd0);
    post("rstmid_cnts", {tx_pkt_cnt, rx_flit_cnt}, 64'd0);
    post("rstmid_drop", 64'(drop_cnt), 64'd0);

    // Round-robin destinations skipping recvPortID=4; credit overflow behaviour.
    cfg_dest_mode = 2'd1; recvPortID = 4'd4;
    ret_limit = ret_done + 4;
    tick(1);
    rst = 1'b0;
    push_pkt(16'd0, 1'b0, 4'd1);
    push_pkt(16'd1, 1'b1, 4'd2);
    push_pkt(16'd2, 1'b0, 4'd3);
    push_pkt(16'd3, 1'b1, 4'd5);
    push_pkt(16'd4, 1'b0, 4'd6);
    wait_tx("tx_rr_first", 1, 30);
    tick(1);
    post("ovf_clear_simul", 64'(err_credit_ovf), 64'd0);
    man_vc = 1'b1;
    man_req = man_req + 1;
    tick(3);
    post("ovf_set", 64'(err_credit_ovf), 64'd1);

    // Sink path: 3-flit packet to self on vc1, then a misrouted flit on vc0.
    rx_flit(1'b1, 4'd4, 1'b0);
    rx_flit(1'b1, 4'd4, 1'b0);
    rx_flit(1'b1, 4'd4, 1'b1);
    flit_in = '0;
    tick(2);
    post("rx_flit_cnt", 64'(rx_flit_cnt), 64'd3);
    post("rx_pkt_cnt", 64'(rx_pkt_cnt), 64'd1);
    post("misroute_clear", 64'(err_misroute), 64'd0);
    rx_flit(1'b0, 4'd9, 1'b1);
    flit_in = '0;
    tick(2);
    post("misroute_set", 64'(err_misroute), 64'd1);
    post("rx_cnts_after", {rx_flit_cnt, rx_pkt_cnt}, {32'd4, 32'd2});
    wait_tx("tx_rr_all", 5, 100);
    tick(30);
    post("sb_rr", 64'(sb_flit.size()), 64'd0);
    post("tx_rr_stall", 64'(tx_pkt_cnt), 64'd5);
    post("ovf_sticky", 64'(err_credit_ovf), 64'd1);

    // LFSR destinations 1,2,4->5,8,0 with full credit echo.
    rst = 1'b1; cfg_dest_mode = 2'd2; recvPortID = 4'd4;
    tick(2);
    ret_limit = ret_done + 1000;
    rst = 1'b0;
    push_pkt(16'd0, 1'b0, 4'd1);
    push_pkt(16'd1, 1'b1, 4'd2);
    push_pkt(16'd2, 1'b0, 4'd5);
    push_pkt(16'd3, 1'b1, 4'd8);
    push_pkt(16'd4, 1'b0, 4'd0);
    wait_tx("tx_lfsr", 5, 100);
    en = 1'b0;
    tick(5);
    post("sb_lfsr", 64'(sb_flit.size()), 64'd0);
    post("sb_cred_empty", 64'(sb_cred.size()), 64'd0);

    begin
      int k = 0;
      while (chk_name.size() > 0 && k < 10) begin
        @(negedge clk);
        k++;
      end
    end
    tick(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
